// File: rtl/myproject_div_pkg.sv
// Shared types and constants for the sequential signed divider.
package myproject_div_pkg;
  localparam int DIN0_W = 25;
  localparam int DIN1_W = 10;
  localparam int DOUT_W = 16;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic signed [DOUT_W-1:0] Q_MAX = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic signed [DOUT_W-1:0] Q_MIN = {1'b1, {(DOUT_W-1){1'b0}}};
endpackage

// File: rtl/myproject_div_if.sv
// Operand/result handshake bundle for the divider.
interface myproject_div_if;
  import myproject_div_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DIN0_W-1:0] din0;
  logic signed [DIN1_W-1:0] din1;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DOUT_W-1:0] dout;
  logic signed [DIN1_W-1:0] rem;
  logic                     div_by_zero;
  logic                     ovf;

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, rem, div_by_zero, ovf
  );
  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, rem, div_by_zero, ovf
  );
endinterface

// File: rtl/myproject_div_step.sv
// One restoring division step on magnitudes: shift in a dividend bit, trial-subtract.
module myproject_div_step #(
  parameter int W = 10
) (
  input  logic [W-1:0] i_pr,
  input  logic         i_bit,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_pr,
  output logic         o_q
);
  logic [W:0] w_sh;

  assign w_sh = {i_pr, i_bit};
  assign o_q  = (w_sh >= {1'b0, i_d});
  // Partial remainder stays below |d1| <= 2^(W-1), so W bits always suffice.
  assign o_pr = o_q ? W'(w_sh - {1'b0, i_d}) : w_sh[W-1:0];
endmodule

// File: rtl/myproject_sdiv_25s_10s_16_seq.sv
// Sequential signed divider: restoring radix-2 on magnitudes, sign fix-up and saturation.
module myproject_sdiv_25s_10s_16_seq
  import myproject_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int DIN0_WIDTH = DIN0_W,
  parameter int DIN1_WIDTH = DIN1_W,
  parameter int DOUT_WIDTH = DOUT_W
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  myproject_div_if.slave   bus
);
  localparam int IW = $clog2(DIN0_WIDTH);
  localparam logic [DIN0_WIDTH-1:0] POS_LIM = DIN0_WIDTH'((1 << (DOUT_WIDTH-1)) - 1);
  localparam logic [DIN0_WIDTH-1:0] NEG_LIM = DIN0_WIDTH'(1 << (DOUT_WIDTH-1));

  state_t                         r_state;
  logic [DIN0_WIDTH-1:0]          r_dvd;
  logic [DIN1_WIDTH-1:0]          r_dsr, r_pr, r_din0_lo;
  logic                           r_qneg, r_dneg;
  logic [IW-1:0]                  r_iter;
  logic                           r_out_valid, r_dz, r_ovf;
  logic signed [DOUT_WIDTH-1:0]   r_dout;
  logic signed [DIN1_WIDTH-1:0]   r_rem;

  logic [DIN0_WIDTH-1:0]          w_abs0, w_qs;
  logic [DIN1_WIDTH-1:0]          w_abs1, w_pr_next, w_rem;
  logic                           w_q_bit, w_dz, w_ovf;
  logic signed [DOUT_WIDTH-1:0]   w_dout;
  logic signed [DIN1_WIDTH-1:0]   w_rem_o;

  assign w_abs0 = bus.din0[DIN0_WIDTH-1] ? $unsigned(-bus.din0) : $unsigned(bus.din0);
  assign w_abs1 = bus.din1[DIN1_WIDTH-1] ? $unsigned(-bus.din1) : $unsigned(bus.din1);

  // r_dvd shifts dividend bits out of the MSB while quotient bits enter at the LSB.
  myproject_div_step #(.W(DIN1_WIDTH)) u_step (
    .i_pr  (r_pr),
    .i_bit (r_dvd[DIN0_WIDTH-1]),
    .i_d   (r_dsr),
    .o_pr  (w_pr_next),
    .o_q   (w_q_bit)
  );

  always_comb begin
    w_dz    = (r_dsr == '0);
    w_qs    = r_qneg ? -r_dvd : r_dvd;
    w_rem   = r_dneg ? -r_pr : r_pr;
    w_ovf   = r_qneg ? (r_dvd > NEG_LIM) : (r_dvd > POS_LIM);
    w_dout  = $signed(w_qs[DOUT_WIDTH-1:0]);
    w_rem_o = $signed(w_rem);
    if (w_dz) begin
      w_dout  = r_dneg ? Q_MIN : Q_MAX;
      w_rem_o = $signed(r_din0_lo);
      w_ovf   = 1'b0;
    end else if (w_ovf) begin
      w_dout  = r_qneg ? Q_MIN : Q_MAX;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state     <= IDLE;
      r_dvd       <= '0;
      r_dsr       <= '0;
      r_pr        <= '0;
      r_din0_lo   <= '0;
      r_qneg      <= 1'b0;
      r_dneg      <= 1'b0;
      r_iter      <= '0;
      r_out_valid <= 1'b0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
      r_dout      <= '0;
      r_rem       <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_dvd     <= w_abs0;
          r_dsr     <= w_abs1;
          r_qneg    <= bus.din0[DIN0_WIDTH-1] ^ bus.din1[DIN1_WIDTH-1];
          r_dneg    <= bus.din0[DIN0_WIDTH-1];
          r_din0_lo <= bus.din0[DIN1_WIDTH-1:0];
          r_pr      <= '0;
          r_iter    <= IW'(DIN0_WIDTH-1);
          r_state   <= CALC;
        end
        CALC: begin
          r_pr  <= w_pr_next;
          r_dvd <= {r_dvd[DIN0_WIDTH-2:0], w_q_bit};
          if (r_iter == '0) r_state <= FIX;
          else              r_iter  <= r_iter - 1'b1;
        end
        FIX: begin
          r_dout      <= w_dout;
          r_rem       <= w_rem_o;
          r_dz        <= w_dz;
          r_ovf       <= w_ovf;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = r_out_valid;
  assign bus.dout        = r_dout;
  assign bus.rem         = r_rem;
  assign bus.div_by_zero = r_dz;
  assign bus.ovf         = r_ovf;
endmodule

// File: tb/tb_myproject_sdiv_25s_10s_16_seq.sv
// Directed plus random checks of the signed divider against C-style integer division.
module tb_myproject_sdiv_25s_10s_16_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  myproject_div_if bus();

  myproject_sdiv_25s_10s_16_seq dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: C semantics (truncate toward zero, remainder takes dividend sign), then saturate.
  task automatic model(input longint a, input longint b, output longint q, output longint r,
                       output bit dz, output bit ov);
    logic signed [9:0] lo;
    dz = 0; ov = 0;
    if (b == 0) begin
      dz = 1;
      q  = (a >= 0) ? 32767 : -32768;
      lo = a[9:0];
      r  = lo;
    end else begin
      q  = a / b;
      r  = a % b;
      ov = (q > 32767) || (q < -32768);
      if (ov) q = (q > 0) ? 32767 : -32768;
    end
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat++;
      if (bus.out_valid) break;
    end
    chk({tag, ":latency"}, lat, exp_lat);
  endtask

  task automatic check_result(input string tag, input longint a, input longint b);
    longint q, r;
    bit dz, ov;
    model(a, b, q, r, dz, ov);
    chk({tag, ":dout"}, bus.dout, q);
    chk({tag, ":rem"}, bus.rem, r);
    chk({tag, ":div_by_zero"}, bus.div_by_zero, dz);
    chk({tag, ":ovf"}, bus.ovf, ov);
  endtask

  task automatic start_op(input string tag, input longint a, input longint b, input logic ordy);
    @(negedge clk);
    chk({tag, ":in_ready"}, bus.in_ready, 1);
    bus.din0      = a[24:0];
    bus.din1      = b[9:0];
    bus.in_valid  = 1'b1;
    bus.out_ready = ordy;
    @(posedge clk);
  endtask

  task automatic run_op(input string tag, input longint a, input longint b);
    start_op(tag, a, b, 1'b1);
    wait_valid(tag, 27);
    check_result(tag, a, b);
  endtask

  initial begin
    longint a, b;
    logic signed [24:0] ra;
    logic signed [9:0]  rb;
    int seen;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.din0      = '0;
    bus.din1      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset:in_ready", bus.in_ready, 1);
    chk("reset:out_valid", bus.out_valid, 0);
    chk("reset:dout", bus.dout, 0);
    chk("reset:rem", bus.rem, 0);
    chk("reset:div_by_zero", bus.div_by_zero, 0);
    chk("reset:ovf", bus.ovf, 0);
    rst_n = 1'b1;

    run_op("neg_pos", -1000, 7);
    run_op("pos_neg", 1000, -7);
    run_op("neg_neg", -1000, -7);
    run_op("zero_dvd", 0, 3);
    run_op("dz_pos", 5, 0);
    run_op("dz_neg", -5, 0);
    run_op("dz_zero", 0, 0);
    run_op("ovf_pos", 8388608, 1);
    run_op("ovf_minmin", -16777216, -1);
    run_op("qmin_exact", -32768, 1);
    run_op("qmax_exact", 32767, 1);
    run_op("qmin_plus", 32768, -1);
    run_op("dsr_min", 100000, -512);
    run_op("dsr_max", -16777216, 511);

    // Back-pressure: outputs frozen, new operands ignored.
    start_op("bp", 12345, -37, 1'b0);
    wait_valid("bp", 27);
    check_result("bp", 12345, -37);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.din0     = $urandom;
      bus.din1     = $urandom;
      @(negedge clk);
      chk("bp:out_valid", bus.out_valid, 1);
      chk("bp:in_ready", bus.in_ready, 0);
      check_result("bp_hold", 12345, -37);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release:out_valid", bus.out_valid, 0);
    chk("bp_release:in_ready", bus.in_ready, 1);

    // Reset mid-calculation drops the operation.
    start_op("abort", 777777, 13, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort:in_ready", bus.in_ready, 1);
    chk("abort:out_valid", bus.out_valid, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk("abort:never_valid", seen, 0);
    run_op("after_abort", -1000, 7);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      a  = ra;
      b  = rb;
      a  = a >>> $urandom_range(0, 20);
      run_op("random", a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
